// File: rtl/sysbus_pkg.sv
// sysbus_pkg: shared Sysbus tag layout, direction/type codes, line geometry and responder states.
package sysbus_pkg;
    localparam int DATA_W     = 64;
    localparam int TAG_W      = 13;
    localparam int DIR_BIT    = 12;
    localparam int TYPE_LSB   = 8;
    localparam int TYPE_W     = 4;
    localparam int ID_W       = 8;
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam logic [TYPE_W-1:0] MEMORY = 4'h1;
    localparam int LINE_BEATS = 8;
    localparam int BEAT_W     = $clog2(LINE_BEATS);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_BURST,
        WR_DATA,
        WR_WAIT,
        WR_RESP
    } state_t;
endpackage

// File: rtl/sysbus_mem_array.sv
// sysbus_mem_array: single-port synchronous word RAM; read data appears the cycle after the address.
module sysbus_mem_array
    import sysbus_pkg::*;
#(
    parameter int WORDS = 65536,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: rtl/sysbus_mem_responder.sv
// sysbus_mem_responder: Sysbus target serving 8-beat line reads and writes from an internal word array.
// Define SYSBUS_RANGE_CHECK_EN to flag addresses beyond MEM_WORDS instead of wrapping them.
module sysbus_mem_responder
    import sysbus_pkg::*;
#(
    parameter int MEM_WORDS  = 65536,
    parameter int RD_LATENCY = 4,
    parameter int WR_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              reqcyc,
    input  logic [DATA_W-1:0] req,
    input  logic [TAG_W-1:0]  reqtag,
    output logic              reqack,
    output logic              respcyc,
    output logic [DATA_W-1:0] resp,
    output logic [TAG_W-1:0]  resptag,
    input  logic              respack
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int BW = AW - BEAT_W;
    localparam int CW = $clog2(RD_LATENCY + WR_LATENCY + 2);
    localparam logic [CW-1:0] RD_END = CW'(RD_LATENCY);
    localparam logic [CW-1:0] WR_END = CW'(WR_LATENCY);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);
`ifdef SYSBUS_RANGE_CHECK_EN
    localparam logic RANGE_CHECK = 1'b1;
`else
    localparam logic RANGE_CHECK = 1'b0;
`endif

    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [BEAT_W-1:0] beat, beat_n, addr_beat;
    logic [BW-1:0] base, base_n;
    logic [TAG_W-1:0] tag_n;
    logic [DATA_W-1:0] resp_n, rdata, rd_word;
    logic oor, oor_n, reqack_n, respcyc_n, we, take;

    sysbus_mem_array #(.WORDS(MEM_WORDS)) u_mem (
        .clk   (clk),
        .we    (we),
        .addr  ({base, addr_beat}),
        .wdata (req),
        .rdata (rdata)
    );

    // A request is held until acked, so the sample taken while reqack is high is a repeat.
    assign take = reqcyc && !reqack;
    assign rd_word = oor ? '1 : rdata;

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        beat_n = beat;
        base_n = base;
        tag_n = resptag;
        oor_n = oor;
        reqack_n = 1'b0;
        respcyc_n = respcyc;
        resp_n = resp;
        we = 1'b0;
        addr_beat = beat;
        case (state)
            IDLE: if (take) begin
                base_n = req[AW+2:6];
                tag_n = reqtag;
                oor_n = RANGE_CHECK && (|req[DATA_W-1:AW+3]);
                reqack_n = 1'b1;
                cnt_n = '0;
                beat_n = '0;
                state_n = (reqtag[DIR_BIT] == READ) ? RD_WAIT : WR_DATA;
            end
            RD_WAIT: begin
                // Keep the RAM one word ahead of resp so beats can stream at one per cycle.
                addr_beat = (cnt == RD_END) ? BEAT_W'(1) : '0;
                cnt_n = cnt + CW'(1);
                if (cnt == RD_END) begin
                    state_n = RD_BURST;
                    respcyc_n = 1'b1;
                    resp_n = rd_word;
                end
            end
            RD_BURST: begin
                addr_beat = beat + (respack ? BEAT_W'(2) : BEAT_W'(1));
                if (respack) begin
                    beat_n = beat + BEAT_W'(1);
                    state_n = (beat == LAST_BEAT) ? IDLE : RD_BURST;
                    respcyc_n = beat != LAST_BEAT;
                    resp_n = (beat == LAST_BEAT) ? '0 : rd_word;
                end
            end
            WR_DATA: if (take) begin
                we = !oor;
                reqack_n = 1'b1;
                beat_n = beat + BEAT_W'(1);
                cnt_n = '0;
                state_n = (beat == LAST_BEAT) ? WR_WAIT : WR_DATA;
            end
            WR_WAIT: begin
                cnt_n = cnt + CW'(1);
                if (cnt == WR_END) begin
                    state_n = WR_RESP;
                    respcyc_n = 1'b1;
                    resp_n = {{(DATA_W-1){1'b0}}, oor};
                end
            end
            WR_RESP: if (respack) begin
                state_n = IDLE;
                respcyc_n = 1'b0;
                resp_n = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt <= '0;
            beat <= '0;
            base <= '0;
            oor <= 1'b0;
            reqack <= 1'b0;
            respcyc <= 1'b0;
            resp <= '0;
            resptag <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            beat <= beat_n;
            base <= base_n;
            oor <= oor_n;
            reqack <= reqack_n;
            respcyc <= respcyc_n;
            resp <= resp_n;
            resptag <= tag_n;
        end
    end
endmodule
